state_matrix_unpacker: RTL and testbench

- Receives 128-bit AES state vectors through a valid/ready handshake and presents each one as a 4x4 byte state matrix on sixteen 8-bit outputs.
- Contains a small FIFO so that the vector source (key expansion / round datapath output) and the matrix consumer (round-transform input stage) are decoupled by up to DEPTH vectors.
- Byte ordering is column-major, MSB first. It is the exact inverse of the team's matrix-to-vector packing.

---
 rtl/state_matrix_unpacker_if.sv | 35 +++
 rtl/state_matrix_unpacker.sv | 85 ++++++++
 tb/tb_state_matrix_unpacker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/state_matrix_unpacker_if.sv
// Handshake bundle between the vector source, the state_matrix_unpacker and the
// matrix consumer. The slave modport is the unpacker's view.
`timescale 1ns/1ps
interface state_matrix_unpacker_if #(
  parameter int unsigned CNT_W = 2
);
  logic [127:0]     i_vector;
  logic             i_valid;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_count;
  logic [7:0] o_dataArray_00, o_dataArray_10, o_dataArray_20, o_dataArray_30;
  logic [7:0] o_dataArray_01, o_dataArray_11, o_dataArray_21, o_dataArray_31;
  logic [7:0] o_dataArray_02, o_dataArray_12, o_dataArray_22, o_dataArray_32;
  logic [7:0] o_dataArray_03, o_dataArray_13, o_dataArray_23, o_dataArray_33;

  modport master (
    output i_vector, i_valid, i_ready,
    input  o_ready, o_valid, o_count,
    input  o_dataArray_00, o_dataArray_10, o_dataArray_20, o_dataArray_30,
    input  o_dataArray_01, o_dataArray_11, o_dataArray_21, o_dataArray_31,
    input  o_dataArray_02, o_dataArray_12, o_dataArray_22, o_dataArray_32,
    input  o_dataArray_03, o_dataArray_13, o_dataArray_23, o_dataArray_33
  );

  modport slave (
    input  i_vector, i_valid, i_ready,
    output o_ready, o_valid, o_count,
    output o_dataArray_00, o_dataArray_10, o_dataArray_20, o_dataArray_30,
    output o_dataArray_01, o_dataArray_11, o_dataArray_21, o_dataArray_31,
    output o_dataArray_02, o_dataArray_12, o_dataArray_22, o_dataArray_32,
    output o_dataArray_03, o_dataArray_13, o_dataArray_23, o_dataArray_33
  );
endinterface

// File: rtl/state_matrix_unpacker.sv
// FIFO-buffered unpacker: 128-bit AES state vectors in, 4x4 column-major byte
// matrix (head entry) out. Full/empty come from the count only.
`timescale 1ns/1ps
module state_matrix_unpacker #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  input logic                    i_flush,
  state_matrix_unpacker_if.slave bus
);
  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [127:0]     mem_q [DEPTH];
  logic             push, pop;
  logic [127:0]     head;

  always_comb begin
    // o_ready is derived from count alone, so a pop while full never frees a slot
    // for a same-cycle push and no consumer->source combinational path exists.
    push     = bus.i_valid && (count_q != FULL);
    pop      = (count_q != '0) && bus.i_ready;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem_q[wr_ptr_q] <= bus.i_vector;
  end

  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign bus.o_ready = (count_q != FULL);
  assign bus.o_valid = (count_q != '0);
  assign bus.o_count = count_q;

  // Byte k (MSB first) lands at row k%4, column k/4.
  assign bus.o_dataArray_00 = head[127:120];
  assign bus.o_dataArray_10 = head[119:112];
  assign bus.o_dataArray_20 = head[111:104];
  assign bus.o_dataArray_30 = head[103:96];
  assign bus.o_dataArray_01 = head[95:88];
  assign bus.o_dataArray_11 = head[87:80];
  assign bus.o_dataArray_21 = head[79:72];
  assign bus.o_dataArray_31 = head[71:64];
  assign bus.o_dataArray_02 = head[63:56];
  assign bus.o_dataArray_12 = head[55:48];
  assign bus.o_dataArray_22 = head[47:40];
  assign bus.o_dataArray_32 = head[39:32];
  assign bus.o_dataArray_03 = head[31:24];
  assign bus.o_dataArray_13 = head[23:16];
  assign bus.o_dataArray_23 = head[15:8];
  assign bus.o_dataArray_33 = head[7:0];
endmodule

// File: tb/tb_state_matrix_unpacker.sv
// Scoreboard bench for state_matrix_unpacker: accepted vectors are queued, a
// negedge monitor pops and compares every delivered matrix.
`timescale 1ns/1ps
module tb_state_matrix_unpacker;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  state_matrix_unpacker_if #(.CNT_W(2)) bus ();

  state_matrix_unpacker #(.DEPTH(2), .CNT_W(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned  n_cmp  = 0;
  int unsigned  n_fail = 0;
  logic [127:0] exp_q [$];
  logic         pend;

  localparam logic [127:0] V0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] VA = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] VB = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] VC = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] VD = 128'hD00D0123_456789AB_CDEF0011_22334455;
  localparam logic [127:0] VE = 128'hE00E1357_9BDF0246_8ACE1122_33445566;
  localparam logic [127:0] VF = 128'hF00F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] VG = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] VH = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
  localparam logic [127:0] VI = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] VJ = 128'h55555555_66666666_77777777_88888888;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Re-pack the matrix column by column, row 0 first.
  function automatic logic [127:0] repack();
    return {bus.o_dataArray_00, bus.o_dataArray_10, bus.o_dataArray_20, bus.o_dataArray_30,
            bus.o_dataArray_01, bus.o_dataArray_11, bus.o_dataArray_21, bus.o_dataArray_31,
            bus.o_dataArray_02, bus.o_dataArray_12, bus.o_dataArray_22, bus.o_dataArray_32,
            bus.o_dataArray_03, bus.o_dataArray_13, bus.o_dataArray_23, bus.o_dataArray_33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Record accepted stimulus once inputs and o_ready are settled for the cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (flush) exp_q.delete();
      else if (bus.i_valid && bus.o_ready) exp_q.push_back(bus.i_vector);
    end
  end

  // Monitor: status against model occupancy, delivered matrices against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [127:0] got;
      chk("mon_count", 128'(bus.o_count), 128'(exp_q.size()));
      chk("mon_valid", 128'(bus.o_valid), 128'(exp_q.size() != 0));
      chk("mon_ready", 128'(bus.o_ready), 128'(exp_q.size() != 2));
      if (bus.o_valid && bus.i_ready && !flush) begin
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("mon_pop_data", repack(), got);
        end
      end else if (!bus.o_valid) begin
        chk("mon_idle_zero", repack(), '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_vector = '0;
    bus.i_ready  = 1'b0;
    pend         = 1'b0;
    sample();
    chk("rst_valid", 128'(bus.o_valid), 128'd0);
    chk("rst_ready", 128'(bus.o_ready), 128'd1);
    chk("rst_count", 128'(bus.o_count), 128'd0);
    chk("rst_matrix", repack(), '0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single vector through an empty FIFO.
    tick(); bus.i_valid = 1'b1; bus.i_vector = V0; bus.i_ready = 1'b1;
    sample(); chk("t1_empty_valid", 128'(bus.o_valid), 128'd0);
    tick(); bus.i_valid = 1'b0;
    sample();
    chk("t1_valid", 128'(bus.o_valid), 128'd1);
    chk("t1_b00", 128'(bus.o_dataArray_00), 128'h00);
    chk("t1_b10", 128'(bus.o_dataArray_10), 128'h11);
    chk("t1_b20", 128'(bus.o_dataArray_20), 128'h22);
    chk("t1_b30", 128'(bus.o_dataArray_30), 128'h33);
    chk("t1_b01", 128'(bus.o_dataArray_01), 128'h44);
    chk("t1_b13", 128'(bus.o_dataArray_13), 128'hDD);
    chk("t1_b33", 128'(bus.o_dataArray_33), 128'hFF);
    tick(); sample();
    chk("t1_after_valid", 128'(bus.o_valid), 128'd0);
    chk("t1_after_zero", repack(), '0);

    // Back-pressure: A, B fill, C waits.
    tick(); bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_vector = VA;
    tick(); bus.i_vector = VB;
    tick(); bus.i_vector = VC;
    sample();
    chk("t2_full_count", 128'(bus.o_count), 128'd2);
    chk("t2_full_ready", 128'(bus.o_ready), 128'd0);
    tick(); sample();
    chk("t2_hold_count", 128'(bus.o_count), 128'd2);
    tick(); bus.i_ready = 1'b1;
    sample(); chk("t2_head_a", repack(), VA);
    tick(); sample(); chk("t2_head_b", repack(), VB);
    tick(); bus.i_valid = 1'b0;
    sample(); chk("t2_head_c", repack(), VC);
    tick(); sample(); chk("t2_drained", 128'(bus.o_valid), 128'd0);

    // Simultaneous push and pop at count 1.
    tick(); bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_vector = VD;
    tick(); bus.i_ready = 1'b1; bus.i_vector = VE;
    sample(); chk("t3_before_count", 128'(bus.o_count), 128'd1);
    chk("t3_before_head", repack(), VD);
    tick(); bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    sample(); chk("t3_count", 128'(bus.o_count), 128'd1);
    chk("t3_head", repack(), VE);
    tick(); bus.i_ready = 1'b1;
    tick(); sample(); chk("t3_drained", 128'(bus.o_valid), 128'd0);

    // Flush at count 2 beats a simultaneous push.
    tick(); bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_vector = VF;
    tick(); bus.i_vector = VG;
    tick(); bus.i_vector = VH; flush = 1'b1;
    sample(); chk("t4_pre_count", 128'(bus.o_count), 128'd2);
    tick(); flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    sample();
    chk("t4_count", 128'(bus.o_count), 128'd0);
    chk("t4_valid", 128'(bus.o_valid), 128'd0);
    chk("t4_ready", 128'(bus.o_ready), 128'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); sample();
      chk("t4_no_h", 128'(bus.o_valid), 128'd0);
    end

    // Asynchronous reset in the middle of a cycle with two entries stored.
    tick(); bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_vector = VI;
    tick(); bus.i_vector = VJ;
    tick(); bus.i_valid = 1'b0;
    sample(); chk("t5_pre_count", 128'(bus.o_count), 128'd2);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_valid", 128'(bus.o_valid), 128'd0);
    chk("t5_count", 128'(bus.o_count), 128'd0);
    chk("t5_ready", 128'(bus.o_ready), 128'd1);
    chk("t5_matrix", repack(), '0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Random traffic; the vector is held while waiting on o_ready.
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (!pend) begin
        bus.i_valid  = ($urandom_range(0, 99) < 60);
        bus.i_vector = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.i_ready = ($urandom_range(0, 99) < 50);
      sample();
      pend = bus.i_valid && !bus.o_ready;
    end

    tick(); bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    for (int n = 0; n < 8 && exp_q.size() != 0; n++) begin
      tick(); sample();
    end
    tick(); sample();
    chk("drain_empty", 128'(exp_q.size()), 128'd0);
    chk("drain_valid", 128'(bus.o_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
